// File: rtl/pipeline_pkg.sv
// Shared types and constants for the five-stage ARM-subset pipeline.
// The IF/ID record defined here is also consumed by the decode stage.
package pipeline_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
        logic               valid;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush inserts a bubble, hold freezes the contents.
// Flush outranks hold so a frozen wrong-path instruction is still discarded.
module if_id_reg
    import pipeline_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    input  logic   hold,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q.pc    <= '0;
            q.instr <= NOP_INSTR;
            q.valid <= 1'b0;
        end else if (flush) begin
            q.pc    <= '0;
            q.instr <= NOP_INSTR;
            q.valid <= 1'b0;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, incrementer and next-PC priority mux
// (branch > freeze > sequential), feeding the IF/ID register.
module fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic [ADDR_W-1:0] pc_out,
    output logic [31:0]       instr_out,
    output logic              valid_out
);

    import pipeline_pkg::*;

    localparam int SLOT_W = pipeline_pkg::ADDR_W;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] branch_target;
    if_id_t            if_id_d;
    if_id_t            if_id_q;

    assign pc_plus4      = pc + ADDR_W'(PC_STEP);
    assign branch_target = branch_addr & ~ADDR_W'(3);
    assign imem_addr     = pc;

    always_comb begin
        pc_next = pc_plus4;
        if (branch_taken) begin
            pc_next = branch_target;
        end else if (freeze) begin
            pc_next = pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    // The record always carries a real fetch; bubbles come from the flush path.
    always_comb begin
        if_id_d.pc    = SLOT_W'(pc_plus4);
        if_id_d.instr = imem_data;
        if_id_d.valid = 1'b1;
    end

    if_id_reg u_if_id_reg (
        .clk   (clk),
        .rst   (rst),
        .flush (branch_taken),
        .hold  (freeze),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    assign pc_out    = ADDR_W'(if_id_q.pc);
    assign instr_out = if_id_q.instr;
    assign valid_out = if_id_q.valid;

endmodule
